// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared state type, constants and sizing helpers for seg_display_driver
package seg_display_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   localparam int SEG_BITS = 7;

   function automatic int page_width(input int digits);
      return SEG_BITS * digits;
   endfunction

   function automatic int page_idx_width(input int pages);
      return (pages > 1) ? $clog2(pages) : 1;
   endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// rtl/seg_display_driver_if.sv - frame request, page data and serial pin bundle; blank_i exists with SEG_DISPLAY_DRIVER_BLANK_EN
interface seg_display_driver_if
   import seg_display_pkg::*;
#(
   parameter int DIGITS_PER_PAGE = 6,
   parameter int PAGES           = 2
) ();

   localparam int PAGE_WIDTH = page_width(DIGITS_PER_PAGE);
   localparam int PW         = page_idx_width(PAGES);

   logic                        start_i;
   logic [PAGES*PAGE_WIDTH-1:0] data_i;
   logic                        mode_i;
   logic [PW-1:0]               page_i;
`ifdef SEG_DISPLAY_DRIVER_BLANK_EN
   logic                        blank_i;
`endif
   logic                        sclk_o;
   logic                        data_o;
   logic                        latch_o;
   logic                        busy_o;
   logic [PW-1:0]               page_o;
   logic                        dropped_o;

`ifdef SEG_DISPLAY_DRIVER_BLANK_EN
   modport master (output start_i, data_i, mode_i, page_i, blank_i,
                   input  sclk_o, data_o, latch_o, busy_o, page_o, dropped_o);
   modport slave  (input  start_i, data_i, mode_i, page_i, blank_i,
                   output sclk_o, data_o, latch_o, busy_o, page_o, dropped_o);
`else
   modport master (output start_i, data_i, mode_i, page_i,
                   input  sclk_o, data_o, latch_o, busy_o, page_o, dropped_o);
   modport slave  (input  start_i, data_i, mode_i, page_i,
                   output sclk_o, data_o, latch_o, busy_o, page_o, dropped_o);
`endif

endinterface

// File: rtl/seg_display_driver_page_rotator.sv
// rtl/seg_display_driver_page_rotator.sv - manual clamp or auto-rotating page choice made at frame acceptance
module page_rotator
   import seg_display_pkg::*;
#(
   parameter int PAGES         = 2,
   parameter int ROTATE_FRAMES = 4,
   localparam int PW           = page_idx_width(PAGES)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          accept,
   input  logic          mode,
   input  logic [PW-1:0] page_req,
   output logic [PW-1:0] page_sel,
   output logic [PW-1:0] page_cur
);

   localparam int CW = $clog2(ROTATE_FRAMES + 1);
   localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
   localparam logic [CW-1:0] LAST_FRAME = CW'(ROTATE_FRAMES - 1);

   logic [PW-1:0] auto_page;
   logic [CW-1:0] frame_cnt;
   logic [PW-1:0] clamped;

   always_comb begin
      clamped  = (page_req > LAST_PAGE) ? LAST_PAGE : page_req;
      page_sel = mode ? auto_page : clamped;
   end

   // A manual frame re-seeds the auto page so rotation resumes from what was last shown.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         auto_page <= '0;
         frame_cnt <= '0;
         page_cur  <= '0;
      end else if (accept) begin
         page_cur <= page_sel;
         if (mode) begin
            if (frame_cnt == LAST_FRAME) begin
               frame_cnt <= '0;
               auto_page <= (auto_page == LAST_PAGE) ? '0 : auto_page + 1'b1;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end else begin
            auto_page <= clamped;
         end
      end
   end

endmodule

// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - serialises one page into a shift-register chain; SEG_DISPLAY_DRIVER_BLANK_EN adds blanking
module seg_display_driver
   import seg_display_pkg::*;
#(
   parameter int DIGITS_PER_PAGE = 6,
   parameter int PAGES           = 2,
   parameter int SCLK_DIV        = 1,
   parameter int MSB_FIRST       = 1,
   parameter int ROTATE_FRAMES   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   seg_display_driver_if.slave  bus
);

   localparam int PAGE_WIDTH = page_width(DIGITS_PER_PAGE);
   localparam int PW         = page_idx_width(PAGES);
   localparam int BW         = $clog2(PAGE_WIDTH + 1);
   localparam int DW         = $clog2(SCLK_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

   state_t                state, state_n;
   logic [PAGE_WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]         bit_cnt, bit_cnt_n;
   logic [DW-1:0]         div_cnt, div_cnt_n;
   logic                  pending, pending_n;
   logic                  dropped, dropped_n;
   logic                  accept;
   logic [PW-1:0]         page_sel;
   logic [PW-1:0]         page_cur;
   logic [PAGE_WIDTH-1:0] page_bits;
   logic [PAGE_WIDTH-1:0] load_bits;

   page_rotator #(
      .PAGES         (PAGES),
      .ROTATE_FRAMES (ROTATE_FRAMES)
   ) u_rotator (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .accept   (accept),
      .mode     (bus.mode_i),
      .page_req (bus.page_i),
      .page_sel (page_sel),
      .page_cur (page_cur)
   );

   always_comb begin
      page_bits = '0;
      for (int p = 0; p < PAGES; p++) begin
         if (page_sel == PW'(p)) page_bits = bus.data_i[p*PAGE_WIDTH +: PAGE_WIDTH];
      end
`ifdef SEG_DISPLAY_DRIVER_BLANK_EN
      load_bits = bus.blank_i ? '0 : page_bits;
`else
      load_bits = page_bits;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         pending <= 1'b0;
         dropped <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         div_cnt <= div_cnt_n;
         pending <= pending_n;
         dropped <= dropped_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      div_cnt_n = div_cnt;
      pending_n = pending;
      dropped_n = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_i || pending) begin
               accept    = 1'b1;
               state_n   = SHIFT_LO;
               shreg_n   = load_bits;
               bit_cnt_n = BW'(PAGE_WIDTH);
               div_cnt_n = '0;
               pending_n = 1'b0;
            end
         end
         SHIFT_LO: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               state_n   = SHIFT_HI;
            end else begin
               div_cnt_n = div_cnt + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               if (bit_cnt > BW'(1)) begin
                  shreg_n   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                  bit_cnt_n = bit_cnt - 1'b1;
                  state_n   = SHIFT_LO;
               end else begin
                  state_n = LATCH;
               end
            end else begin
               div_cnt_n = div_cnt + 1'b1;
            end
         end
         LATCH: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               state_n   = IDLE;
            end else begin
               div_cnt_n = div_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // Only one request is buffered; a second one while busy is reported and lost.
      if ((state != IDLE) && bus.start_i) begin
         if (pending) dropped_n = 1'b1;
         else         pending_n = 1'b1;
      end
   end

   always_comb begin
      bus.sclk_o    = (state == SHIFT_HI);
      bus.latch_o   = (state == LATCH);
      bus.busy_o    = (state != IDLE);
      bus.data_o    = 1'b0;
      if ((state == SHIFT_LO) || (state == SHIFT_HI))
         bus.data_o = (MSB_FIRST != 0) ? shreg[PAGE_WIDTH-1] : shreg[0];
      bus.page_o    = page_cur;
      bus.dropped_o = dropped;
   end

endmodule
